// File: rtl/nf_cpu2ahb_bridge_if.sv
// Port bundles for the CPU-to-AHB bridge: the CPU data-memory request channel
// and the AHB-Lite master channel that feeds the router/decoder.

interface nf_cpu_dm_if;
  logic [31:0] addr_dm;
  logic [31:0] wd_dm;
  logic        we_dm;
  logic [1:0]  size_dm;
  logic        req_dm;
  logic        req_ack_dm;
  logic [31:0] rd_dm;
  logic        err_dm;

  // master = CPU side, slave = bridge side
  modport master (
    output addr_dm, wd_dm, we_dm, size_dm, req_dm,
    input  req_ack_dm, rd_dm, err_dm
  );
  modport slave (
    input  addr_dm, wd_dm, we_dm, size_dm, req_dm,
    output req_ack_dm, rd_dm, err_dm
  );
endinterface

interface nf_ahb_if;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hready;
  logic        hresp;

  // master = bridge side, slave = router side
  modport master (
    output haddr, hwdata, hwrite, htrans, hsize, hburst,
    input  hrdata, hready, hresp
  );
  modport slave (
    input  haddr, hwdata, hwrite, htrans, hsize, hburst,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/nf_cpu2ahb_bridge.sv
// CPU data-memory request/ack to single AHB-Lite NONSEQ transfers, one outstanding.
// Optional wait-state abort is compiled in with the NF_AHB_TIMEOUT_EN macro.

module nf_cpu2ahb_bridge #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       hclk,
  input  logic       hreset,
  nf_cpu_dm_if.slave cpu,
  nf_ahb_if.master   ahb
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } state_t;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout_cfg
    $error("nf_cpu2ahb_bridge: TIMEOUT_CYC must be at least 1");
  end

  state_t      state_reg;
  logic [31:0] haddr_reg;
  logic [31:0] hwdata_reg;
  logic [31:0] wd_reg;
  logic [31:0] rd_reg;
  logic [1:0]  htrans_reg;
  logic [1:0]  size_reg;
  logic        hwrite_reg;
  logic        ack_reg;
  logic        err_reg;

  logic [1:0]  size_in;
  logic        misaligned_in;
  logic [31:0] wdata_lane;
  logic [31:0] rd_shift;
  logic [31:0] rd_lane;
  logic        tmo_hit;

  always_comb begin
    size_in       = (cpu.size_dm == 2'b11) ? 2'b10 : cpu.size_dm;
    misaligned_in = ((size_in == 2'b01) && cpu.addr_dm[0]) ||
                    ((size_in == 2'b10) && (cpu.addr_dm[1:0] != 2'b00));
  end

  // Write lanes replicate the right-aligned CPU operand; read lanes pick the
  // addressed bytes back down to bit 0 and zero the bytes beyond the size.
  assign rd_shift = ahb.hrdata >> {haddr_reg[1:0], 3'b000};

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wdata_lane[gi*8 +: 8] = (size_reg == 2'b00) ? wd_reg[7:0] :
                                   (size_reg == 2'b01) ? wd_reg[(gi%2)*8 +: 8] :
                                                         wd_reg[gi*8 +: 8];
    assign rd_lane[gi*8 +: 8] = ((size_reg == 2'b10) || (gi == 0) ||
                                 ((gi == 1) && (size_reg == 2'b01)))
                                ? rd_shift[gi*8 +: 8] : 8'h00;
  end

`ifdef NF_AHB_TIMEOUT_EN
  localparam int CNT_RAW = $clog2(TIMEOUT_CYC + 1);
  localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);

  logic [CNT_W-1:0] wait_cnt_reg;
  logic             waiting;

  assign waiting = ((state_reg == ST_ADDR) || (state_reg == ST_DATA)) && !ahb.hready;
  assign tmo_hit = waiting && (wait_cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

  // Any exit from ADDR/DATA happens on hready=1 or a timeout, so clearing
  // here also clears the count on every state entry.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      wait_cnt_reg <= '0;
    end else if (waiting && !tmo_hit) begin
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end else begin
      wait_cnt_reg <= '0;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_reg  <= ST_IDLE;
      haddr_reg  <= '0;
      hwdata_reg <= '0;
      wd_reg     <= '0;
      rd_reg     <= '0;
      htrans_reg <= HTRANS_IDLE;
      size_reg   <= '0;
      hwrite_reg <= 1'b0;
      ack_reg    <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      ack_reg <= 1'b0;
      if (tmo_hit) begin
        state_reg  <= ST_RESP;
        htrans_reg <= HTRANS_IDLE;
        ack_reg    <= 1'b1;
        err_reg    <= 1'b1;
        rd_reg     <= '0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (cpu.req_dm) begin
              haddr_reg  <= cpu.addr_dm;
              wd_reg     <= cpu.wd_dm;
              hwrite_reg <= cpu.we_dm;
              size_reg   <= size_in;
              // Misaligned requests never reach the bus; read data is left as is.
              if (misaligned_in) begin
                state_reg <= ST_RESP;
                ack_reg   <= 1'b1;
                err_reg   <= 1'b1;
              end else begin
                state_reg  <= ST_ADDR;
                htrans_reg <= HTRANS_NONSEQ;
              end
            end
          end
          ST_ADDR: begin
            if (ahb.hready) begin
              state_reg  <= ST_DATA;
              htrans_reg <= HTRANS_IDLE;
              hwdata_reg <= wdata_lane;
            end
          end
          ST_DATA: begin
            if (ahb.hready) begin
              state_reg <= ST_RESP;
              ack_reg   <= 1'b1;
              err_reg   <= ahb.hresp;
              if (!hwrite_reg) begin
                rd_reg <= ahb.hresp ? 32'h0 : rd_lane;
              end
            end
          end
          ST_RESP: state_reg <= ST_IDLE;
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign ahb.haddr      = haddr_reg;
  assign ahb.hwdata     = hwdata_reg;
  assign ahb.hwrite     = hwrite_reg;
  assign ahb.htrans     = htrans_reg;
  assign ahb.hsize      = {1'b0, size_reg};
  assign ahb.hburst     = 3'b000;
  assign cpu.req_ack_dm = ack_reg;
  assign cpu.rd_dm      = rd_reg;
  assign cpu.err_dm     = err_reg;

endmodule
